// File: rtl/lsu_axil_pkg.sv
// rtl/lsu_axil_pkg.sv - LSU type encodings, fault/state enums and access size helpers
package lsu_axil_pkg;

  typedef enum logic [2:0] {
    LOAD_NONE = 3'd0,
    LOAD_LB   = 3'd1,
    LOAD_LH   = 3'd2,
    LOAD_LW   = 3'd3,
    LOAD_LBU  = 3'd4,
    LOAD_LHU  = 3'd5,
    LOAD_LWU  = 3'd6,
    LOAD_LD   = 3'd7
  } load_type_e;

  typedef enum logic [2:0] {
    STORE_NONE = 3'd0,
    STORE_SB   = 3'd1,
    STORE_SH   = 3'd2,
    STORE_SW   = 3'd3,
    STORE_SD   = 3'd4
  } store_type_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_BUS_ERR  = 2'd2
  } lsu_fault_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_WR   = 3'd3,
    ST_B    = 3'd4,
    ST_RESP = 3'd5
  } lsu_state_e;

  function automatic int load_bytes(logic [2:0] t);
    case (t)
      LOAD_LB, LOAD_LBU:  return 1;
      LOAD_LH, LOAD_LHU:  return 2;
      LOAD_LW, LOAD_LWU:  return 4;
      LOAD_LD:            return 8;
      default:            return 0;
    endcase
  endfunction

  // Undefined store encodings report zero bytes; legality is judged separately.
  function automatic int store_bytes(logic [2:0] t);
    case (t)
      STORE_SB: return 1;
      STORE_SH: return 2;
      STORE_SW: return 4;
      STORE_SD: return 8;
      default:  return 0;
    endcase
  endfunction

  function automatic logic load_signed(logic [2:0] t);
    return (t == LOAD_LB) || (t == LOAD_LH) || (t == LOAD_LW);
  endfunction

  function automatic logic type_legal(logic [2:0] lt, logic [2:0] st, int xlen);
    if (lt != LOAD_NONE)
      return ((lt != LOAD_LWU) && (lt != LOAD_LD)) || (xlen == 64);
    return (st <= STORE_SW) || ((st == STORE_SD) && (xlen == 64));
  endfunction

endpackage

// File: rtl/lsu_axil_if.sv
// rtl/lsu_axil_if.sv - AXI-lite AR/R/AW/W/B channel bundle between the LSU and the memory arbiter
interface lsu_axil_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [XLEN-1:0]       rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [XLEN-1:0]       wdata;
  logic [XLEN/8-1:0]     wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );

endinterface

// File: rtl/lsu_axil_align.sv
// rtl/lsu_axil_align.sv - lane placement of store data/strobes and extraction/extension of load data
module lsu_align
  import lsu_axil_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                   st_type,
  input  logic [$clog2(XLEN/8)-1:0]    st_offset,
  input  logic [XLEN-1:0]              st_wdata,
  output logic [XLEN-1:0]              lane_wdata,
  output logic [XLEN/8-1:0]            lane_strb,
  input  logic [2:0]                   ld_type,
  input  logic [$clog2(XLEN/8)-1:0]    ld_offset,
  input  logic [XLEN-1:0]              ld_rdata,
  output logic [XLEN-1:0]              ld_data
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  logic [7:0] wb_in  [STRB_W];
  logic [7:0] wb_out [STRB_W];
  logic [7:0] rb_in  [STRB_W];
  logic [7:0] rb_out [STRB_W];

  for (genvar g = 0; g < STRB_W; g++) begin : g_bytes
    assign wb_in[g]             = st_wdata[8*g +: 8];
    assign rb_in[g]             = ld_rdata[8*g +: 8];
    assign lane_wdata[8*g +: 8] = wb_out[g];
    assign ld_data[8*g +: 8]    = rb_out[g];
  end

  // Lane arithmetic is modulo the word width, so misaligned accesses wrap inside the word.
  always_comb begin
    int               st_n;
    int               ld_n;
    logic             sign;
    logic [OFF_W-1:0] lane;
    st_n      = store_bytes(st_type);
    ld_n      = load_bytes(ld_type);
    sign      = 1'b0;
    lane      = '0;
    wb_out    = '{default: 8'h00};
    rb_out    = '{default: 8'h00};
    lane_strb = '0;
    for (int i = 0; i < STRB_W; i++) begin
      lane = st_offset + OFF_W'(i);
      if (i < st_n) begin
        wb_out[lane]    = wb_in[i];
        lane_strb[lane] = 1'b1;
      end
    end
    for (int i = 0; i < STRB_W; i++) begin
      lane = ld_offset + OFF_W'(i);
      if (i < ld_n) rb_out[i] = rb_in[lane];
      if (i == ld_n - 1) sign = rb_in[lane][7];
    end
    if (load_signed(ld_type)) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (i >= ld_n) rb_out[i] = {8{sign}};
      end
    end
  end

endmodule

// File: rtl/lsu_axil.sv
// rtl/lsu_axil.sv - single-outstanding AXI-lite load/store unit, XLEN 32/64
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W/D accesses answer MISALIGN without a bus cycle.
module lsu_axil
  import lsu_axil_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_load_type_i,
  input  logic [2:0]            req_store_type_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [XLEN-1:0]       req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [XLEN-1:0]       resp_rdata_o,
  output logic [1:0]            resp_fault_o,
  lsu_axil_if.master            axi
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
    $fatal(1, "lsu_axil: XLEN must be 32 or 64");
  end

  lsu_state_e            state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            ld_type_q;
  logic [XLEN-1:0]       wdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic [XLEN-1:0]       rdata_q;
  lsu_fault_e            fault_q;
  logic                  aw_done, w_done, aw_done_n, w_done_n;
  logic                  req_ready, req_fire, req_is_load, req_legal, req_misalign;
  logic [XLEN-1:0]       st_lane_wdata, ld_ext;
  logic [STRB_W-1:0]     st_lane_strb;

  assign req_is_load = (req_load_type_i != LOAD_NONE);
  assign req_legal   = type_legal(req_load_type_i, req_store_type_i, XLEN);
  assign req_fire    = req_valid_i && (state == ST_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  int               req_bytes;
  logic [OFF_W-1:0] req_mask;
  assign req_bytes    = req_is_load ? load_bytes(req_load_type_i) : store_bytes(req_store_type_i);
  assign req_mask     = (req_bytes > 1) ? OFF_W'(req_bytes - 1) : '0;
  assign req_misalign = |(req_addr_i[OFF_W-1:0] & req_mask);
`else
  assign req_misalign = 1'b0;
`endif

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_type    (req_store_type_i),
    .st_offset  (req_addr_i[OFF_W-1:0]),
    .st_wdata   (req_wdata_i),
    .lane_wdata (st_lane_wdata),
    .lane_strb  (st_lane_strb),
    .ld_type    (ld_type_q),
    .ld_offset  (addr_q[OFF_W-1:0]),
    .ld_rdata   (axi.rdata),
    .ld_data    (ld_ext)
  );

  assign aw_done_n    = aw_done | axi.awready;
  assign w_done_n     = w_done | axi.wready;
  assign req_ready_o  = req_ready & ~rst_i;
  assign resp_rdata_o = rdata_q;
  assign resp_fault_o = fault_q;
  assign axi.araddr   = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign axi.awaddr   = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign axi.wdata    = wdata_q;
  assign axi.wstrb    = strb_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n      = state;
    req_ready    = 1'b0;
    resp_valid_o = 1'b0;
    axi.arvalid  = 1'b0;
    axi.rready   = 1'b0;
    axi.awvalid  = 1'b0;
    axi.wvalid   = 1'b0;
    axi.bready   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid_i) begin
          if (!req_legal || req_misalign) state_n = ST_RESP;
          else if (req_is_load)           state_n = ST_AR;
          else                            state_n = ST_WR;
        end
      end
      ST_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_n = ST_R;
      end
      ST_R: begin
        axi.rready = 1'b1;
        if (axi.rvalid) state_n = ST_RESP;
      end
      ST_WR: begin
        axi.awvalid = !aw_done;
        axi.wvalid  = !w_done;
        if (aw_done_n && w_done_n) state_n = ST_B;
      end
      ST_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) state_n = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      ld_type_q <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rdata_q   <= '0;
      fault_q   <= FAULT_NONE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      if (req_fire) begin
        addr_q    <= req_addr_i;
        ld_type_q <= req_load_type_i;
        wdata_q   <= st_lane_wdata;
        strb_q    <= st_lane_strb;
        rdata_q   <= '0;
        fault_q   <= (req_legal && req_misalign) ? FAULT_MISALIGN : FAULT_NONE;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end
      if (state == ST_WR) begin
        aw_done <= aw_done_n;
        w_done  <= w_done_n;
      end
      if ((state == ST_R) && axi.rvalid) begin
        if (axi.rresp != 2'b00) begin
          fault_q <= FAULT_BUS_ERR;
          rdata_q <= '0;
        end else begin
          rdata_q <= ld_ext;
        end
      end
      if ((state == ST_B) && axi.bvalid && (axi.bresp != 2'b00)) fault_q <= FAULT_BUS_ERR;
    end
  end

endmodule

// File: tb/tb_lsu_axil.sv
// tb/tb_lsu_axil.sv - self-checking bench for lsu_axil at XLEN=64 with a byte-level reference model
module tb_lsu_axil;
  import lsu_axil_pkg::*;

  localparam int XLEN = 64;
  localparam int AW   = 32;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic [2:0]      req_load_type_i = '0;
  logic [2:0]      req_store_type_i = '0;
  logic [AW-1:0]   req_addr_i = '0;
  logic [XLEN-1:0] req_wdata_i = '0;
  logic            resp_valid_o;
  logic            resp_ready_i = 1'b0;
  logic [XLEN-1:0] resp_rdata_o;
  logic [1:0]      resp_fault_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  lsu_axil_if #(.XLEN(XLEN), .ADDR_WIDTH(AW)) axi_bus ();

  lsu_axil #(.XLEN(XLEN), .ADDR_WIDTH(AW)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_load_type_i  (req_load_type_i),
    .req_store_type_i (req_store_type_i),
    .req_addr_i       (req_addr_i),
    .req_wdata_i      (req_wdata_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .resp_rdata_o     (resp_rdata_o),
    .resp_fault_o     (resp_fault_o),
    .axi              (axi_bus)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_ld_bytes(logic [2:0] lt);
    case (lt)
      LOAD_LB, LOAD_LBU: return 1;
      LOAD_LH, LOAD_LHU: return 2;
      LOAD_LW, LOAD_LWU: return 4;
      LOAD_LD:           return 8;
      default:           return 0;
    endcase
  endfunction

  function automatic int m_st_bytes(logic [2:0] st);
    case (st)
      STORE_NONE: return 0;
      STORE_SB:   return 1;
      STORE_SH:   return 2;
      STORE_SW:   return 4;
      STORE_SD:   return 8;
      default:    return -1;
    endcase
  endfunction

  function automatic logic [63:0] byte_mask(int n);
    return (n >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
  endfunction

  // Word rotated right by the byte offset, truncated to the access size, then extended.
  function automatic logic [63:0] exp_load(logic [63:0] rd, int off, logic [2:0] lt);
    logic [127:0] two;
    logic [63:0]  v, m;
    int           n;
    two = {rd, rd} >> (8 * off);
    n   = m_ld_bytes(lt);
    m   = byte_mask(n);
    v   = two[63:0] & m;
    if ((lt == LOAD_LB || lt == LOAD_LH || lt == LOAD_LW) && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [63:0] exp_wdata(logic [63:0] wd, int off, int n);
    logic [127:0] t;
    t = {64'd0, wd & byte_mask(n)} << (8 * off);
    return t[63:0] | t[127:64];
  endfunction

  function automatic logic [7:0] exp_strb(int off, int n);
    logic [15:0] t;
    t = (16'((1 << n) - 1)) << off;
    return t[7:0] | t[15:8];
  endfunction

  task automatic run_op(input string tag, input logic [2:0] lt, input logic [2:0] st,
                        input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                        input logic [1:0] xresp, input int da, input int dw, input int db, input int dr);
    int          off, n, t0, mx, exp_lat;
    bit          is_load, legal, mis, use_bus;
    logic [63:0] exp_rd;
    logic [1:0]  exp_f;
    off     = int'(addr[2:0]);
    is_load = (lt != LOAD_NONE);
    n       = is_load ? m_ld_bytes(lt) : m_st_bytes(st);
    legal   = is_load || (n >= 0);
    mis     = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis     = legal && (n > 1) && ((addr % n) != 0);
`endif
    use_bus = legal && !mis;
    exp_f   = !legal ? FAULT_NONE : mis ? FAULT_MISALIGN : (xresp != 2'b00) ? FAULT_BUS_ERR : FAULT_NONE;
    exp_rd  = (use_bus && is_load && xresp == 2'b00) ? exp_load(rd, off, lt) : 64'd0;
    mx      = (da > dw) ? da : dw;

    req_valid_i = 1'b1; req_load_type_i = lt; req_store_type_i = st;
    req_addr_i = addr; req_wdata_i = wd;
    chk({tag, ".req_ready"}, req_ready_o, 1);
    t0 = cyc;
    step();
    req_valid_i = 1'b0; req_load_type_i = '0; req_store_type_i = '0; req_wdata_i = '0;

    if (use_bus && is_load) begin
      for (int c = 0; c <= da; c++) begin
        chk({tag, ".arvalid"}, axi_bus.arvalid, 1);
        chk({tag, ".araddr"}, axi_bus.araddr, addr & ~32'h7);
        chk({tag, ".awvalid_ld"}, axi_bus.awvalid, 0);
        axi_bus.arready = (c == da);
        step();
      end
      axi_bus.arready = 1'b0;
      for (int c = 0; c <= db; c++) begin
        chk({tag, ".rready"}, axi_bus.rready, 1);
        chk({tag, ".arvalid_r"}, axi_bus.arvalid, 0);
        axi_bus.rvalid = (c == db);
        axi_bus.rdata  = (c == db) ? rd : {$urandom, $urandom};
        axi_bus.rresp  = (c == db) ? xresp : 2'($urandom);
        step();
      end
      axi_bus.rvalid = 1'b0;
    end else if (use_bus) begin
      for (int c = 0; c <= mx; c++) begin
        chk({tag, ".awvalid"}, axi_bus.awvalid, (c <= da));
        chk({tag, ".wvalid"}, axi_bus.wvalid, (c <= dw));
        chk({tag, ".awaddr"}, axi_bus.awaddr, addr & ~32'h7);
        chk({tag, ".wdata"}, axi_bus.wdata, exp_wdata(wd, off, n));
        chk({tag, ".wstrb"}, axi_bus.wstrb, exp_strb(off, n));
        axi_bus.awready = (c == da);
        axi_bus.wready  = (c == dw);
        step();
      end
      axi_bus.awready = 1'b0; axi_bus.wready = 1'b0;
      for (int c = 0; c <= db; c++) begin
        chk({tag, ".bready"}, axi_bus.bready, 1);
        chk({tag, ".aw_w_idle"}, {axi_bus.awvalid, axi_bus.wvalid}, 0);
        axi_bus.bvalid = (c == db);
        axi_bus.bresp  = (c == db) ? xresp : 2'($urandom);
        step();
      end
      axi_bus.bvalid = 1'b0;
    end

    exp_lat = !use_bus ? 1 : is_load ? (3 + da + db) : (3 + mx + db);
    chk({tag, ".latency"}, cyc - t0, exp_lat);
    for (int c = 0; c <= dr; c++) begin
      chk({tag, ".resp_valid"}, resp_valid_o, 1);
      chk({tag, ".resp_rdata"}, resp_rdata_o, exp_rd);
      chk({tag, ".resp_fault"}, resp_fault_o, exp_f);
      chk({tag, ".bus_quiet"}, {axi_bus.arvalid, axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}, 0);
      resp_ready_i = (c == dr);
      step();
    end
    resp_ready_i = 1'b0;
    chk({tag, ".resp_done"}, resp_valid_o, 0);
    chk({tag, ".ready_again"}, req_ready_o, 1);
  endtask

  initial begin
    axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0; axi_bus.rdata = '0; axi_bus.rresp = '0;
    axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.bvalid = 1'b0; axi_bus.bresp = '0;
    step();
    step();
    chk("reset.req_ready", req_ready_o, 0);
    chk("reset.resp", {resp_valid_o, resp_fault_o}, 0);
    chk("reset.rdata", resp_rdata_o, 0);
    chk("reset.valids", {axi_bus.arvalid, axi_bus.rready, axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}, 0);
    chk("reset.addr", {axi_bus.araddr, axi_bus.awaddr}, 0);
    chk("reset.wdata", {axi_bus.wdata, axi_bus.wstrb}, 0);
    rst_i = 1'b0;
    step();

    run_op("lb_sign",  LOAD_LB,   STORE_NONE, 32'h8000_0003, 64'd0, 64'h0000_0000_8012_3456, 2'b00, 0, 0, 0, 0);
    run_op("sh_lane",  LOAD_NONE, STORE_SH,   32'h0000_0102, 64'hABCD, 64'd0, 2'b00, 0, 2, 0, 0);
    run_op("ld_full",  LOAD_LD,   STORE_NONE, 32'h0000_0010, 64'd0, 64'h1122_3344_5566_7788, 2'b00, 1, 0, 2, 0);
    run_op("lwu_hi",   LOAD_LWU,  STORE_NONE, 32'h0000_0014, 64'd0, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 0, 1);
    run_op("lw_buserr", LOAD_LW,  STORE_NONE, 32'h0000_0008, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 2'b10, 0, 0, 1, 4);
    run_op("lw_mis",   LOAD_LW,   STORE_NONE, 32'h0000_0002, 64'd0, 64'h8899_AABB_CCDD_EEFF, 2'b00, 0, 0, 0, 0);
    run_op("sw_mis",   LOAD_NONE, STORE_SW,   32'h0000_0006, 64'h1234_5678, 64'd0, 2'b00, 0, 0, 0, 0);
    run_op("st_ill",   LOAD_NONE, 3'd5,       32'h0000_0000, 64'h55, 64'd0, 2'b00, 0, 0, 0, 2);
    run_op("none_none", LOAD_NONE, STORE_NONE, 32'h0000_0003, 64'hFFFF, 64'd0, 2'b00, 0, 0, 0, 0);
    run_op("sd_berr",  LOAD_NONE, STORE_SD,   32'h0000_0018, 64'h0102_0304_0506_0708, 64'd0, 2'b11, 1, 1, 0, 0);
    run_op("sb_w1st",  LOAD_NONE, STORE_SB,   32'h0000_0025, 64'h7E, 64'd0, 2'b00, 3, 1, 0, 0);
    run_op("lhu_top",  LOAD_LHU,  STORE_NONE, 32'h0000_0036, 64'd0, 64'hF00F_0000_0000_0000, 2'b00, 2, 0, 0, 0);

    // Reset while the write channels are still waiting for their handshakes.
    req_valid_i = 1'b1; req_load_type_i = LOAD_NONE; req_store_type_i = STORE_SW;
    req_addr_i = 32'h20; req_wdata_i = 64'hCAFE;
    step();
    req_valid_i = 1'b0;
    chk("rst_wr.in_wr", {axi_bus.awvalid, axi_bus.wvalid}, 2'b11);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_wr.valids", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}, 0);
    chk("rst_wr.req_ready", req_ready_o, 0);
    chk("rst_wr.resp", resp_valid_o, 0);
    step();
    rst_i = 1'b0;
    step();
    chk("rst_wr.idle", req_ready_o, 1);
    run_op("post_rst", LOAD_NONE, STORE_SW, 32'h0000_0024, 64'h89AB_CDEF, 64'd0, 2'b00, 0, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      logic [2:0]  lt, st;
      logic [31:0] addr;
      logic [1:0]  xr;
      lt   = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      st   = (lt == 3'd0) ? 3'($urandom_range(0, 7)) : 3'd0;
      addr = 32'h1000 + 32'($urandom_range(0, 63)) * 8 + 32'($urandom_range(0, 7));
      xr   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_op($sformatf("rnd%0d", k), lt, st, addr, {$urandom, $urandom}, {$urandom, $urandom}, xr,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
